// File: rtl/window_scan_ctrl.sv
// Window scan controller for the SAD motion-estimation datapath.
// Walks every legal window position of a frame in raster order, issues the
// broadcast base offset for the 16-lane adder bank, collects one SAD per
// position and tracks the minimum SAD with its coordinates.
// Optional build macro: SAD_EARLY_EXIT_EN -- a zero SAD ends the scan at once.
module window_scan_ctrl #(
   parameter int unsigned WIN_W = 4,
   parameter int unsigned WIN_H = 4,
   parameter int unsigned DIM_W = 8,
   parameter int unsigned SAD_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIM_W-1:0] frame_cols,
   input  logic [DIM_W-1:0] frame_rows,
   output logic [31:0]      base_addr,
   output logic             base_valid,
   input  logic             base_ready,
   input  logic [SAD_W-1:0] sad_in,
   input  logic             sad_valid,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [SAD_W-1:0] best_sad,
   output logic [DIM_W-1:0] best_row,
   output logic [DIM_W-1:0] best_col
);

   localparam int unsigned ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_SAD,
      FINISH
   } state_t;

   state_t state, state_d;

   logic [DIM_W-1:0]  cols_q, rows_q, row_q, col_q;
   logic [DIM_W-1:0]  cols_d, rows_d, row_d, col_d;
   logic [DIM_W-1:0]  best_row_d, best_col_d;
   logic [SAD_W-1:0]  best_sad_d;
   logic [ADDR_W-1:0] base_addr_d;
   logic              err_d, base_valid_d, busy_d, done_d;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next-state, position walk and best-SAD tracking
   always_comb begin
      state_d     = state;
      cols_d      = cols_q;
      rows_d      = rows_q;
      row_d       = row_q;
      col_d       = col_q;
      base_addr_d = base_addr;
      best_sad_d  = best_sad;
      best_row_d  = best_row;
      best_col_d  = best_col;
      err_d       = err;

      case (state)
         IDLE: begin
            if (start) begin
               cols_d      = frame_cols;
               rows_d      = frame_rows;
               row_d       = '0;
               col_d       = '0;
               base_addr_d = '0;
               best_sad_d  = '1;
               err_d       = 1'b0;
               if (frame_cols < DIM_W'(WIN_W) || frame_rows < DIM_W'(WIN_H)) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (base_ready) state_d = WAIT_SAD;
         end
         WAIT_SAD: begin
            if (sad_valid) begin
               // strict less-than keeps the earliest raster position on ties
               if (sad_in < best_sad) begin
                  best_sad_d = sad_in;
                  best_row_d = row_q;
                  best_col_d = col_q;
               end
               if (col_q < cols_q - DIM_W'(WIN_W)) begin
                  col_d       = col_q + DIM_W'(1);
                  base_addr_d = base_addr + ADDR_W'(1);
                  state_d     = ISSUE;
               end else if (row_q < rows_q - DIM_W'(WIN_H)) begin
                  // last column sits WIN_W pixels before the next row start
                  col_d       = '0;
                  row_d       = row_q + DIM_W'(1);
                  base_addr_d = base_addr + ADDR_W'(WIN_W);
                  state_d     = ISSUE;
               end else begin
                  state_d = FINISH;
               end
`ifdef SAD_EARLY_EXIT_EN
               if (sad_in == '0) state_d = FINISH;
`else
`endif
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      base_valid_d = (state_d == ISSUE);
      busy_d       = (state_d == ISSUE) || (state_d == WAIT_SAD);
      done_d       = (state_d == FINISH);
   end

   // Registered datapath and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cols_q     <= '0;
         rows_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         base_addr  <= '0;
         base_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         best_sad   <= '1;
         best_row   <= '0;
         best_col   <= '0;
      end else begin
         cols_q     <= cols_d;
         rows_q     <= rows_d;
         row_q      <= row_d;
         col_q      <= col_d;
         base_addr  <= base_addr_d;
         base_valid <= base_valid_d;
         busy       <= busy_d;
         done       <= done_d;
         err        <= err_d;
         best_sad   <= best_sad_d;
         best_row   <= best_row_d;
         best_col   <= best_col_d;
      end
   end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl: directed and randomized scans
// compared against a raster-walk reference model of the window search.
module tb_window_scan_ctrl;

   localparam int unsigned WIN_W = 4;
   localparam int unsigned WIN_H = 4;
   localparam int unsigned DIM_W = 8;
   localparam int unsigned SAD_W = 32;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [DIM_W-1:0] frame_cols, frame_rows;
   logic [31:0]      base_addr;
   logic             base_valid, base_ready;
   logic [SAD_W-1:0] sad_in;
   logic             sad_valid;
   logic             busy, done, err;
   logic [SAD_W-1:0] best_sad;
   logic [DIM_W-1:0] best_row, best_col;

   int n_checks = 0;
   int n_fails  = 0;

   logic [31:0] sad_tab [16][16];

   window_scan_ctrl #(.WIN_W(WIN_W), .WIN_H(WIN_H), .DIM_W(DIM_W), .SAD_W(SAD_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .frame_cols(frame_cols), .frame_rows(frame_rows),
      .base_addr(base_addr), .base_valid(base_valid), .base_ready(base_ready),
      .sad_in(sad_in), .sad_valid(sad_valid),
      .busy(busy), .done(done), .err(err),
      .best_sad(best_sad), .best_row(best_row), .best_col(best_col)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports mismatches
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic fill_tab(input logic [31:0] v);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            sad_tab[r][c] = v;
   endtask

   // One complete scan: model the expected walk, drive the handshakes, compare
   task automatic scan(input int cols, input int rows, input int st_r, input int st_c,
                       input int st_len, input bit rnd);
      int          pos_r[$], pos_c[$];
      logic [31:0] exp_best;
      int          exp_r, exp_c, npos, idx, cyc, stall_left;
      bit          exp_err, stop, waiting, seen_done, held, rdy;

      // reference model: raster walk with strict-minimum search
      exp_best = 32'hFFFF_FFFF;
      exp_r = 0; exp_c = 0; stop = 1'b0;
      exp_err = (cols < int'(WIN_W)) || (rows < int'(WIN_H));
      if (!exp_err) begin
         for (int r = 0; r <= rows - int'(WIN_H); r++)
            for (int c = 0; c <= cols - int'(WIN_W); c++)
               if (!stop) begin
                  pos_r.push_back(r);
                  pos_c.push_back(c);
                  if (sad_tab[r][c] < exp_best) begin
                     exp_best = sad_tab[r][c]; exp_r = r; exp_c = c;
                  end
`ifdef SAD_EARLY_EXIT_EN
                  if (sad_tab[r][c] == 32'd0) stop = 1'b1;
`else
`endif
               end
      end
      npos = pos_r.size();

      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      frame_cols = DIM_W'(cols);
      frame_rows = DIM_W'(rows);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      idx = 0; cyc = 0; waiting = 1'b0; seen_done = 1'b0; held = 1'b0;
      stall_left = st_len;
      while (cyc < 5000) begin
         base_ready = 1'b0;
         sad_valid  = 1'b0;
         sad_in     = '0;
         if (done) begin
            seen_done = 1'b1;
            break;
         end
         if (held) check("valid_hold", 32'(base_valid), 32'd1);
         held = 1'b0;
         if (waiting) begin
            check("one_outstanding", 32'(base_valid), 32'd0);
            if (!rnd || ($urandom_range(0, 1) == 1)) begin
               sad_valid = 1'b1;
               sad_in    = sad_tab[pos_r[idx]][pos_c[idx]];
               idx++;
               waiting = 1'b0;
            end
         end else if (base_valid) begin
            check("busy_scan", 32'(busy), 32'd1);
            check("extra_window", 32'(idx < npos), 32'd1);
            if (idx < npos) begin
               check("base_addr", base_addr, 32'(pos_r[idx] * cols + pos_c[idx]));
               if (pos_r[idx] == st_r && pos_c[idx] == st_c && stall_left > 0) begin
                  rdy = 1'b0;
                  stall_left--;
               end else begin
                  rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
               end
               base_ready = rdy;
               if (rdy) waiting = 1'b1;
               else     held = 1'b1;
            end
            // stray SAD while issuing must be ignored
            if (rnd && ($urandom_range(0, 3) == 0)) sad_valid = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end

      check("done_seen", 32'(seen_done), 32'd1);
      check("windows", 32'(idx), 32'(npos));
      check("err", 32'(err), 32'(exp_err));
      check("busy_done", 32'(busy), 32'd0);
      check("best_sad", best_sad, exp_best);
      if (exp_err) begin
         check("err_latency", 32'(cyc <= 1), 32'd1);
      end else begin
         check("best_row", 32'(best_row), 32'(exp_r));
         check("best_col", 32'(best_col), 32'(exp_c));
      end
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("best_hold", best_sad, exp_best);
   endtask

   // Abort a scan with reset at position (0,1)
   task automatic reset_mid_scan();
      bit hit, any_done;
      fill_tab(32'd5);
      @(negedge clk);
      frame_cols = DIM_W'(8);
      frame_rows = DIM_W'(8);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         base_ready = 1'b0; sad_valid = 1'b0;
         if (base_valid && base_addr == 32'd1) begin
            hit = 1'b1;
         end else begin
            base_ready = base_valid;
            sad_valid  = !base_valid;
            sad_in     = 32'd5;
            @(negedge clk);
         end
      end
      check("reach_pos01", 32'(hit), 32'd1);
      base_ready = 1'b0; sad_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(base_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_addr", base_addr, 32'd0);
      check("rst_best", best_sad, 32'hFFFF_FFFF);
      @(negedge clk);
      rst_n = 1'b1;
      any_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done) any_done = 1'b1;
      end
      check("no_done_after_abort", 32'(any_done), 32'd0);
   endtask

   initial begin
      int cols, rows;
      rst_n = 1'b0; start = 1'b0; frame_cols = '0; frame_rows = '0;
      base_ready = 1'b0; sad_valid = 1'b0; sad_in = '0;
      repeat (3) @(negedge clk);
      check("rst_busy0", 32'(busy), 32'd0);
      check("rst_done0", 32'(done), 32'd0);
      check("rst_err0", 32'(err), 32'd0);
      check("rst_bv0", 32'(base_valid), 32'd0);
      check("rst_ba0", base_addr, 32'd0);
      check("rst_bs0", best_sad, 32'hFFFF_FFFF);
      check("rst_br0", 32'(best_row), 32'd0);
      check("rst_bc0", 32'(best_col), 32'd0);
      rst_n = 1'b1;

      fill_tab(32'd37);
      scan(4, 4, -1, -1, 0, 1'b0);

      fill_tab(32'd10);
      sad_tab[1][2] = 32'd3;
      scan(6, 5, -1, -1, 0, 1'b0);

      fill_tab(32'd20);
      sad_tab[1][1] = 32'd9;
      sad_tab[0][2] = 32'd9;
      scan(6, 5, 0, 1, 5, 1'b0);

      scan(3, 8, -1, -1, 0, 1'b0);
      scan(8, 2, -1, -1, 0, 1'b1);

      reset_mid_scan();
      fill_tab(32'd12);
      scan(4, 4, -1, -1, 0, 1'b1);

      fill_tab(32'd50);
      sad_tab[0][1] = 32'd0;
      scan(8, 8, -1, -1, 0, 1'b1);

      for (int t = 0; t < 14; t++) begin
         cols = int'($urandom_range(2, 12));
         rows = int'($urandom_range(2, 12));
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
               sad_tab[r][c] = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
         scan(cols, rows, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
